main_mem_ctrl: RTL and testbench
================================

// Module: main_mem_ctrl
// PURPOSE
//   Memory-side responder for the 2-way write-back data cache. Serves cache refill
//   reads after a fixed access latency and absorbs dirty-line writebacks.
//   Writebacks go through a posted write buffer, with read-after-write forwarding.
//   Sits between the cache's miss/writeback port and the word-addressed main memory array.
// PARAMETERS
//   ADDR_W    10  word-address width; memory holds 2**ADDR_W 32-bit words
//   LATENCY   4   cycles from read acceptance to response; legal range >= 1
//   WB_DEPTH  4   write-buffer entries; power of 2, >= 2
// PORTS
//   clk       in   1   clock; all state updates on the rising edge
//   reset     in   1   asynchronous, active-low reset
//   rd_req    in   1   refill read request
//   rd_addr   in   32  byte address; word index = rd_addr[ADDR_W+1:2]
//   rd_ready  out  1   controller can accept a read this cycle
//   rd_valid  out  1   one-cycle pulse; rd_data is valid
//   rd_data   out  32  refill data; held until the next response
//   wb_req    in   1   dirty-line writeback request
//   wb_addr   in   32  byte address; word index = wb_addr[ADDR_W+1:2]
//   wb_data   in   32  writeback data
//   wb_ready  out  1   write buffer not full
//   busy      out  1   read FSM not in IDLE, or write buffer non-empty
// BEHAVIOUR
//   Reset (reset low, async)
//     - outputs: rd_ready=0, wb_ready=0, rd_valid=0, rd_data=0, busy=0
//     - buffer empty, FSM in IDLE
//     - rd_ready=1 and wb_ready=1 from the first edge after release
//     - the memory array is not reset
//   Reset mid-operation
//     - an outstanding read is dropped and produces no rd_valid
//     - buffered writebacks are discarded
//   Addressing
//     - addr[1:0] and bits above ADDR_W+1 are ignored; aliasing wraps silently
//   Write buffer (circular FIFO, WB_DEPTH entries)
//     - push on wb_req && wb_ready; wb_ready = !full, computed from registered state
//     - pop: one entry per cycle while non-empty; the head is written to the array at that edge
//     - push and pop in the same cycle are legal; occupancy is unchanged
//     - the pointers wrap modulo WB_DEPTH
//     - when full, wb_ready=0 and wb_req is ignored; the requester holds it
//   Read FSM: IDLE -> WAIT -> RESP -> IDLE
//     - IDLE: rd_ready=1. On rd_req, accept at edge E0, latch the word address and
//       load the counter with LATENCY-1; go to WAIT, or to RESP if LATENCY=1.
//     - WAIT: rd_ready=0; decrement the counter; on 0 go to RESP at edge E0+LATENCY-1.
//     - RESP: rd_valid=1 for exactly one cycle, starting after edge E0+LATENCY.
//       rd_ready=0 during RESP; next IDLE.
//     - Throughput: one read per LATENCY+1 cycles.
//   Read data: captured at the edge entering RESP
//     - source: the youngest valid buffer entry matching the word address (full compare),
//       else the array word
//     - includes writebacks accepted on the same edge or during WAIT (write-first ordering)
//     - a head entry popped on the capture edge is still forwarded
//   rd_req and wb_req in the same cycle are both accepted; the two ports are independent
//   rd_req outside IDLE is ignored; the requester holds it
// TESTING
//   T1 Basic read: preload word 0x010 = 0xDEADBEEF; rd_req with addr 0x40
//      -> rd_valid pulse 4 cycles after accept, rd_data = 0xDEADBEEF.
//   T2 Forwarding: wb 0x40 <- 0x11111111, then wb 0x40 <- 0x22222222;
//      rd 0x40 on the next cycle -> rd_data = 0x22222222.
//   T3 Full buffer: hold drain off via back-to-back pushes with rd idle. Push 5 writes
//      (0x0,0x4,0x8,0xC,0x10) in consecutive cycles -> each push is accepted or stalled
//      per wb_ready; all 5 land; array read-back is correct; busy falls after drain.
//   T4 Same-edge: rd_req and wb_req (addr 0x80, data 0xA5A5A5A5) asserted together
//      -> rd_data = 0xA5A5A5A5.
//   T5 Reset mid-read: assert reset in WAIT -> rd_valid never pulses;
//      rd_ready=1 at the first edge after release.
//   T6 Alias/wrap, ADDR_W=10: wb addr 0x1000 <- 0x5; rd addr 0x0000 -> rd_data = 0x5.

Source files
------------

// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl
//   Memory-side responder for the 2-way write-back data cache. Refill reads are
//   answered a fixed LATENCY after acceptance; dirty-line writebacks are posted
//   into a small circular write buffer that drains one entry per cycle into the
//   word-addressed array. Reads forward from the buffer (youngest match wins).
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   rd_req/rd_addr      refill read request, byte address
//   rd_ready            read FSM idle and able to accept
//   rd_valid/rd_data    one-cycle response pulse; data held until next response
//   wb_req/wb_addr/wb_data  writeback request, byte address and data
//   wb_ready            write buffer not full
//   busy                read in flight or write buffer non-empty
module main_mem_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int LATENCY  = 4,
  parameter int WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  input  logic        wb_req,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  output logic        busy
);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(LATENCY + 1);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [31:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wb_addr [WB_DEPTH];
  logic [31:0]       r_wb_data [WB_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_alive;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [ADDR_W-1:0] r_rd_idx;
  logic              r_rd_valid;
  logic [31:0]       r_rd_data;

  logic [ADDR_W-1:0] w_rd_idx;
  logic [ADDR_W-1:0] w_wb_idx;
  logic [ADDR_W-1:0] w_cap_idx;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_accept;
  logic              w_capture;
  logic [31:0]       w_fwd_data;
  logic [PTR_W-1:0]  w_slot;
  logic              w_unused;

  // Byte-offset and high address bits are deliberately dropped (aliasing wraps).
  assign w_unused = ^{rd_addr[31:ADDR_W+2], rd_addr[1:0], wb_addr[31:ADDR_W+2], wb_addr[1:0]};
  assign w_rd_idx = rd_addr[ADDR_W+1:2];
  assign w_wb_idx = wb_addr[ADDR_W+1:2];

  // r_alive keeps both ready outputs low until the first edge after reset release.
  assign w_full   = (r_count == CNT_W'(WB_DEPTH));
  assign wb_ready = r_alive && !w_full;
  assign rd_ready = r_alive && (r_state == S_IDLE);
  assign w_push   = wb_req && wb_ready;
  assign w_pop    = (r_count != '0);
  assign busy     = (r_state != S_IDLE) || (r_count != '0);
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

  // Write buffer control
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Write buffer storage and array (not reset)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_tail] <= w_wb_idx;
      r_wb_data[r_tail] <= wb_data;
    end
    if (w_pop) r_mem[r_wb_addr[r_head]] <= r_wb_data[r_head];
  end

  // With LATENCY=1 capture happens on the accept edge, before r_rd_idx is loaded.
  assign w_cap_idx = (r_state == S_IDLE) ? w_rd_idx : r_rd_idx;

  // Forwarding priority: array, then buffer oldest-to-youngest, then the
  // writeback being pushed on this same edge.
  always_comb begin
    w_fwd_data = r_mem[w_cap_idx];
    w_slot     = r_head;
    for (int i = 0; i < WB_DEPTH; i++) begin
      w_slot = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_wb_addr[w_slot] == w_cap_idx))
        w_fwd_data = r_wb_data[w_slot];
    end
    if (w_push && (w_wb_idx == w_cap_idx)) w_fwd_data = wb_data;
  end

  // Read FSM next state
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rd_req && rd_ready) begin
          w_accept     = 1'b1;
          w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT:  if (r_lat_cnt == LAT_W'(1)) w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_capture = (w_next_state == S_RESP) && (r_state != S_RESP);

  // Read FSM state, latency counter and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_lat_cnt  <= '0;
      r_alive    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_alive    <= 1'b1;
      r_state    <= w_next_state;
      r_rd_valid <= (r_state == S_RESP);
      if (w_accept)
        r_lat_cnt <= LAT_W'(LATENCY - 1);
      else if (r_state == S_WAIT)
        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
      if (w_capture) r_rd_data <= w_fwd_data;
    end
  end

  // Latched read word address
  always_ff @(posedge clk) begin
    if (w_accept) r_rd_idx <= w_rd_idx;
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
module tb_main_mem_ctrl;
  logic        clk;
  logic        reset;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        busy;

  int n_err;
  int n_chk;

  main_mem_ctrl #(.ADDR_W(10), .LATENCY(4), .WB_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ready(wb_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_wb(input logic [31:0] a, input logic [31:0] d);
    int g;
    g = 0;
    wb_req = 1'b1; wb_addr = a; wb_data = d;
    while (!wb_ready && g < 20) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    wb_req = 1'b0;
  endtask

  // Read with an optional writeback to the same address issued on edge
  // E0+wb_edge (E0 = accept edge); wb_edge < 0 means no writeback.
  task automatic rd_with_wb(input logic [31:0] a, input int wb_edge, input logic [31:0] wd,
                            output logic [31:0] d, output int lat);
    int g;
    g = 0;
    rd_req = 1'b1; rd_addr = a;
    while (!rd_ready && g < 20) begin @(posedge clk); #1; g++; end
    lat = -1; d = 32'hx;
    for (int k = 0; k <= 12; k++) begin
      wb_req = (k == wb_edge); wb_addr = a; wb_data = wd;
      @(posedge clk); #1;
      rd_req = 1'b0;
      if (rd_valid && lat < 0) begin lat = k; d = rd_data; end
    end
    wb_req = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    rd_with_wb(a, -1, 32'h0, d, lat);
  endtask

  initial begin
    vec_t        vecs [14];
    logic [31:0] d;
    int          lat;
    int          n;
    int          pulses;
    int          g;
    logic        ok;

    n_err = 0; n_chk = 0;
    reset = 1'b0; rd_req = 1'b0; rd_addr = '0;
    wb_req = 1'b0; wb_addr = '0; wb_data = '0;

    vecs[0]  = '{1'b0, 32'h0000_0040, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0100, 32'h1234_5678};
    vecs[3]  = '{1'b0, 32'h0000_0104, 32'hCAFE_F00D};
    vecs[4]  = '{1'b1, 32'h0000_0104, 32'hCAFE_F00D};
    vecs[5]  = '{1'b1, 32'h0000_0100, 32'h1234_5678};
    vecs[6]  = '{1'b0, 32'h0000_1000, 32'h0000_0005};
    vecs[7]  = '{1'b1, 32'h0000_0000, 32'h0000_0005};
    vecs[8]  = '{1'b1, 32'h0000_1040, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 32'h0000_0043, 32'hDEAD_BEEF};
    vecs[10] = '{1'b0, 32'h0000_0FFC, 32'h0000_0077};
    vecs[11] = '{1'b1, 32'h0000_0FFC, 32'h0000_0077};
    vecs[12] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0077};
    vecs[13] = '{1'b1, 32'h0000_0104, 32'hCAFE_F00D};

    // Reset state
    #12;
    check("rst_rd_ready", {31'b0, rd_ready}, 32'd0);
    check("rst_wb_ready", {31'b0, wb_ready}, 32'd0);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    check("rel_rd_ready_pre_edge", {31'b0, rd_ready}, 32'd0);
    @(posedge clk); #1;
    check("rel_rd_ready", {31'b0, rd_ready}, 32'd1);
    check("rel_wb_ready", {31'b0, wb_ready}, 32'd1);

    // Table: writebacks and reads (T1 basic read, T6 aliasing, boundaries)
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_rd) begin
        do_read(vecs[i].addr, d, lat);
        check($sformatf("vec%0d_data", i), d, vecs[i].data);
        check($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
      end else begin
        do_wb(vecs[i].addr, vecs[i].data);
      end
    end

    // T2: two writebacks to one address, read right after -> youngest
    do_wb(32'h40, 32'h1111_1111);
    do_wb(32'h40, 32'h2222_2222);
    do_read(32'h40, d, lat);
    check("t2_data", d, 32'h2222_2222);
    check("t2_lat", 32'(lat), 32'd4);

    // T4: writeback on the accept edge
    rd_with_wb(32'h80, 0, 32'hA5A5_A5A5, d, lat);
    check("t4_data", d, 32'hA5A5_A5A5);
    check("t4_lat", 32'(lat), 32'd4);
    // writeback one edge before capture: head popped on the capture edge
    rd_with_wb(32'h200, 2, 32'h0000_0003, d, lat);
    check("fwd_head_pop_data", d, 32'h0000_0003);
    check("fwd_head_pop_lat", 32'(lat), 32'd4);
    // writeback on the capture edge itself
    rd_with_wb(32'h200, 3, 32'h0000_0004, d, lat);
    check("fwd_same_edge_data", d, 32'h0000_0004);
    check("fwd_same_edge_lat", 32'(lat), 32'd4);
    // writeback after capture must not be seen
    rd_with_wb(32'h200, 4, 32'h0000_0005, d, lat);
    check("fwd_after_cap_data", d, 32'h0000_0004);
    do_read(32'h200, d, lat);
    check("fwd_after_cap_landed", d, 32'h0000_0005);

    // T3: five back-to-back pushes, each advancing only when accepted
    n = 0; g = 0;
    wb_req = 1'b1;
    while (n < 5 && g < 40) begin
      wb_addr = 32'(n * 4); wb_data = 32'h3000_0000 + 32'(n);
      ok = wb_ready;
      @(posedge clk); #1;
      if (ok) n++;
      g++;
    end
    wb_req = 1'b0;
    check("t3_pushes", 32'(n), 32'd5);
    check("t3_busy_draining", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    check("t3_busy_drained", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      do_read(32'(i * 4), d, lat);
      check($sformatf("t3_rb%0d", i), d, 32'h3000_0000 + 32'(i));
    end

    // T5: reset while the read is in WAIT
    rd_req = 1'b1; rd_addr = 32'h40;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(posedge clk); #1;
    check("t5_busy_in_wait", {31'b0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_rd_ready", {31'b0, rd_ready}, 32'd0);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    check("t5_rst_rd_data", rd_data, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    check("t5_rel_pre_edge", {31'b0, rd_ready}, 32'd0);
    pulses = 0;
    @(posedge clk); #1;
    check("t5_rel_rd_ready", {31'b0, rd_ready}, 32'd1);
    check("t5_rel_wb_ready", {31'b0, wb_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (rd_valid) pulses++;
      @(posedge clk); #1;
    end
    check("t5_no_rd_valid", 32'(pulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
